// File: rtl/sample_ram_reader.sv
// Streams count consecutive words from a 1-cycle-latency RAM onto a valid/ready output.
// Optional SAMPLE_RAM_READER_CHECKSUM_EN adds a 16-bit running sum of transferred words.
module sample_ram_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef SAMPLE_RAM_READER_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  done_q, done_d;
    logic                  pop;
    logic                  issue;
    logic [2:0]            pending;

    // Valid/ready: a word moves on any rising edge with m_valid & m_ready; the FIFO head
    // is held unchanged while m_valid is high and m_ready is low.
    assign pop     = (occ_q != 2'd0) && m_ready;
    // Words the FIFO must still absorb after this edge; issuing needs room for one more.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue   = (state_q == ST_RUN) && (remaining_q != '0) && (pending < 3'd2) && !abort;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        done_d      = 1'b0;

        if (inflight_q) begin
            fifo_d[wr_ptr_q] = ram_dout;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (issue) begin
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = start_addr;
                    remaining_d = count;
                    if (count != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (remaining_d == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (occ_d == 2'd0 && !inflight_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            addr_d      = addr_q;
            remaining_d = '0;
            inflight_d  = 1'b0;
            rd_ptr_d    = 1'b0;
            wr_ptr_d    = 1'b0;
            occ_d       = 2'd0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            fifo_q[0]   <= fifo_d[0];
            fifo_q[1]   <= fifo_d[1];
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            done_q      <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign ram_en   = issue;
    assign ram_addr = addr_q;
    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = fifo_q[rd_ptr_q];

`ifdef SAMPLE_RAM_READER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (abort) begin
            csum_d = '0;
        end else if (state_q == ST_IDLE && start) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q + 16'(m_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_sample_ram_reader.sv
// Self-checking bench for sample_ram_reader: RAM model, negedge scoreboard, directed and random commands.
module tb_sample_ram_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] count;
    logic       abort;
    logic       busy;
    logic       done;
    logic       ram_en;
    logic [3:0] ram_addr;
    logic [7:0] ram_dout;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
`ifdef SAMPLE_RAM_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    sample_ram_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
`ifdef SAMPLE_RAM_READER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // clock / reset / environment
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram_mem [16];
    initial ram_dout = 8'h00;
    always @(posedge clk) if (ram_en) ram_dout <= ram_mem[ram_addr];

    logic rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b1;
    initial m_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: expected words built from the command and RAM contents
    logic [7:0]  exp_q[$];
    logic [15:0] exp_sum     = '0;
    logic [3:0]  exp_raddr   = '0;
    int          cmd_cnt     = 0;
    int          cmd_issued  = 0;
    int          outstanding = 0;
    int          xfer_total  = 0;
    int          done_cnt    = 0;
    logic        prev_stall  = 1'b0;
    logic [7:0]  prev_data   = '0;

    always @(negedge clk) begin
        if (!rst_n || abort) begin
            exp_q.delete();
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            logic will_pop;
            if (prev_stall) begin
                check_eq("stall_valid", 32'(m_valid), 1);
                check_eq("stall_data", 32'(m_data), 32'(prev_data));
            end
            will_pop = m_valid && m_ready;
            if (ram_en) begin
                check_eq("en_room", 32'((outstanding - int'(will_pop)) < 2), 1);
                check_eq("en_busy", 32'(busy), 1);
                check_eq("raddr", 32'(ram_addr), 32'(exp_raddr));
                exp_raddr = exp_raddr + 4'd1;
                cmd_issued++;
                outstanding++;
            end
            if (will_pop) begin
                check_eq("xfer_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_eq("xfer_data", 32'(m_data), 32'(exp_q.pop_front()));
                outstanding--;
                xfer_total++;
            end
            if (done) begin
                done_cnt++;
                check_eq("done_busy", 32'(busy), 0);
                check_eq("done_all_sent", 32'(exp_q.size()), 0);
                check_eq("done_reads", 32'(cmd_issued), 32'(cmd_cnt));
`ifdef SAMPLE_RAM_READER_CHECKSUM_EN
                check_eq("checksum", 32'(checksum), 32'(exp_sum));
`endif
            end
            if (start && !busy) begin
                cmd_cnt    = int'(count);
                cmd_issued = 0;
                exp_raddr  = start_addr;
                exp_sum    = '0;
                for (int i = 0; i < cmd_cnt; i++) begin
                    exp_q.push_back(ram_mem[(int'(start_addr) + i) % 16]);
                    exp_sum = exp_sum + 16'(ram_mem[(int'(start_addr) + i) % 16]);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // driver tasks (all called at posedge + 1)
    int e0 = 0;

    task automatic do_start(input logic [3:0] sa, input logic [4:0] cnt);
        start      = 1'b1;
        start_addr = sa;
        count      = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic wait_done(output int lat);
        int k = 0;
        while (!done && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("done_seen", 32'(done), 1);
        lat = cyc - e0;
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 32'(done), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_ram_en"}, 32'(ram_en), 0);
        check_eq({tag, "_ram_addr"}, 32'(ram_addr), 0);
        check_eq({tag, "_m_valid"}, 32'(m_valid), 0);
        check_eq({tag, "_m_data"}, 32'(m_data), 0);
`ifdef SAMPLE_RAM_READER_CHECKSUM_EN
        check_eq({tag, "_checksum"}, 32'(checksum), 0);
`endif
    endtask

    initial begin
        int lat;
        int base;
        for (int i = 0; i < 16; i++) ram_mem[i] = 8'(i + 16);
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        abort      = 1'b0;
        #1;
        check_all_zero("reset");
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // full sweep at full speed, with latency
        base = done_cnt;
        do_start(4'd0, 5'd16);
        check_eq("first_en", 32'(ram_en), 1);
        check_eq("first_addr", 32'(ram_addr), 0);
        check_eq("busy_after_start", 32'(busy), 1);
        check_eq("valid_e0", 32'(m_valid), 0);
        idle(1);
        check_eq("valid_e1", 32'(m_valid), 0);
        idle(1);
        check_eq("valid_e2", 32'(m_valid), 1);
        check_eq("data_e2", 32'(m_data), 32'h10);
        wait_done(lat);
        check_eq("sweep_latency", 32'(lat), 18);
`ifdef SAMPLE_RAM_READER_CHECKSUM_EN
        check_eq("sweep_checksum", 32'(checksum), 32'h0178);
`endif
        check_eq("sweep_done_count", 32'(done_cnt - base), 1);

        // address wrap
        base = done_cnt;
        do_start(4'd14, 5'd4);
        wait_done(lat);
        check_eq("wrap_latency", 32'(lat), 6);
        check_eq("wrap_done_count", 32'(done_cnt - base), 1);

        // backpressure
        rdy_rand = 1'b1;
        base = done_cnt;
        do_start(4'd3, 5'd8);
        wait_done(lat);
        check_eq("bp_done_count", 32'(done_cnt - base), 1);
        rdy_rand = 1'b0;
        idle(2);

        // empty command
        base = done_cnt;
        do_start(4'd7, 5'd0);
        check_eq("zero_done", 32'(done), 1);
        check_eq("zero_busy", 32'(busy), 0);
        check_eq("zero_en", 32'(ram_en), 0);
        idle(1);
        check_eq("zero_done_clear", 32'(done), 0);
        check_eq("zero_busy_after", 32'(busy), 0);
        check_eq("zero_valid", 32'(m_valid), 0);
        check_eq("zero_done_count", 32'(done_cnt - base), 1);

        // start while busy is ignored
        base = done_cnt;
        do_start(4'd0, 5'd6);
        idle(2);
        start = 1'b1; start_addr = 4'd9; count = 5'd3;
        idle(1);
        start = 1'b0;
        wait_done(lat);
        check_eq("busy_start_done_count", 32'(done_cnt - base), 1);

        // abort after the 3rd transfer, then a fresh command
        base = xfer_total;
        do_start(4'd0, 5'd10);
        for (int k = 0; k < 50 && (xfer_total - base) < 3; k++) idle(1);
        check_eq("abort_reached_3", 32'(xfer_total - base), 3);
        base  = done_cnt;
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        check_eq("abort_valid", 32'(m_valid), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
`ifdef SAMPLE_RAM_READER_CHECKSUM_EN
        check_eq("abort_checksum", 32'(checksum), 0);
`endif
        idle(4);
        check_eq("abort_no_done", 32'(done_cnt - base), 0);
        do_start(4'd5, 5'd2);
        idle(2);
        check_eq("post_abort_first", 32'(m_data), 32'h15);
        wait_done(lat);
        check_eq("post_abort_latency", 32'(lat), 4);
        check_eq("post_abort_done_count", 32'(done_cnt - base), 1);

        // asynchronous reset mid-stream
        base = done_cnt;
        do_start(4'd0, 5'd16);
        idle(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        idle(2);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midreset_no_done", 32'(done_cnt - base), 0);
        do_start(4'd3, 5'd4);
        wait_done(lat);
        check_eq("post_reset_latency", 32'(lat), 6);
        check_eq("post_reset_done_count", 32'(done_cnt - base), 1);

        // random contents, commands and backpressure
        for (int i = 0; i < 16; i++) ram_mem[i] = 8'($urandom_range(0, 255));
        rdy_rand = 1'b1;
        for (int t = 0; t < 8; t++) begin
            base = done_cnt;
            do_start(4'($urandom_range(0, 15)), 5'($urandom_range(1, 16)));
            wait_done(lat);
            check_eq("rand_done_count", 32'(done_cnt - base), 1);
        end
        rdy_rand = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_ram_reader.md
Name: sample_ram_reader

Overview:
- Read-side master for the sample RAM (1-cycle registered read latency; read data updates only when en=1).
- On a start command it drives en/r_addr to stream count consecutive words from start_addr, wrapping at 2^ADDR_WIDTH.
- Presents the words on a valid/ready stream to the host-link/FFT consumer, with full backpressure and no lost or duplicated words.

Parameters:
- DATA_WIDTH, 8: sample word width; matches the RAM.
- ADDR_WIDTH, 4: RAM address width; depth is 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first address to read
- count  in  ADDR_WIDTH+1  words to read, 0..2^ADDR_WIDTH
- abort  in  1  synchronous flush to IDLE
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse after the last word handshakes
- ram_en  out  1  RAM enable; drives the RAM en input
- ram_addr  out  ADDR_WIDTH  RAM read address; drives r_addr
- ram_dout  in  DATA_WIDTH  RAM read data
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- checksum  out  16  present only with the macro

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE.
  - busy=0, done=0, ram_en=0, ram_addr=0, m_valid=0, m_data=0, checksum=0.
  - Internal counters, in-flight flag and buffer cleared.
  - Reset mid-stream drops all data; no done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 at a clock edge latches start_addr and count.
  - If count!=0, go to RUN and busy=1 from the next cycle.
  - If count==0, stay in IDLE, pulse done in the next cycle, issue no reads.
- RUN:
  - ram_en=1 with ram_addr=current address in any cycle where remaining>0 and (buffer occupancy + in-flight read - pop this cycle) < 2.
  - Each issued read decrements remaining and increments the address modulo 2^ADDR_WIDTH (15 -> 0 at the default).
  - Data returns on ram_dout in the cycle after issue and is written into a 2-entry output FIFO at the following edge.
  - When remaining reaches 0, go to DRAIN.
- DRAIN:
  - When the FIFO is empty and no read is in flight, pulse done for one cycle, return to IDLE, busy=0.
  - done is coincident with busy falling.
- Latency: start sampled at edge E0 -> first ram_en in the cycle after E0 -> m_valid=1 after edge E0+2.
- Throughput: one word per cycle when m_ready is held high.
- Stream rules:
  - A transfer occurs when m_valid & m_ready at a rising edge.
  - m_valid never falls without a transfer.
  - m_data is stable while m_valid=1 and m_ready=0.
  - Words come out in address order.
- Backpressure: ram_en=0 whenever the FIFO plus in-flight read would exceed 2 entries, so RAM data is never overwritten before capture.
- start while busy: ignored.
- abort=1:
  - At the next edge: return to IDLE, flush the FIFO, m_valid=0, discard any in-flight read, no done pulse.
  - abort has priority over start in the same cycle.
- ram_en is 0 in IDLE; ram_addr holds its last value.

Optional Feature:
- Macro: SAMPLE_RAM_READER_CHECKSUM_EN.
- Defined:
  - checksum port exists.
  - At command acceptance it clears to 0, including count==0 commands.
  - On every stream transfer it adds zero-extended m_data modulo 2^16.
  - Holds its value after done until the next accepted start.
  - abort and reset clear it.
- Undefined: no checksum port, no logic.

Test Plan:
- RAM preloaded with addr+0x10; start_addr=0, count=16, m_ready=1:
  - m_data = 0x10..0x1F on 16 consecutive cycles, first m_valid 2 cycles after start.
  - done pulses once after the 0x1F transfer; checksum=0x0178 when the macro is defined.
- Wrap: start_addr=14, count=4 -> addresses 14, 15, 0, 1 read; stream 0x1E, 0x1F, 0x10, 0x11.
- Backpressure: count=8 with m_ready toggling 1,0,0,1 pseudo-randomly:
  - No drop or duplicate; m_data stable while stalled.
  - ram_en never issues with FIFO + in-flight at 2.
- count=0: done pulses in the cycle after start; busy stays 0; ram_en and m_valid never assert.
- abort asserted after the 3rd transfer of count=10:
  - Next cycle m_valid=0, busy=0, no done.
  - A following start_addr=5, count=2 streams 0x15, 0x16.
- rst_n driven low mid-stream asynchronously: all outputs 0 immediately; after release a new start works normally.
